// File: rtl/an_scan_controller.sv
// rtl/an_scan_controller.sv - multiplexed seven-segment scanner with per-slot blanking gap
module an_scan_controller #(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic                                                  clk,
  input  logic                                                  reset_n,
  input  logic                                                  enable,
  input  logic [4*NUM_DIGITS-1:0]                               digits,
  input  logic [NUM_DIGITS-1:0]                                 dp_in,
  input  logic [NUM_DIGITS-1:0]                                 digit_en,
  output logic [NUM_DIGITS-1:0]                                 an,
  output logic [6:0]                                            seg,
  output logic                                                  dp,
  output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] digit_idx,
  output logic                                                  scan_tick
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [3:0]            lat_nib, live_nib, cur_nib;
  logic                  lat_dp, live_dp, cur_dp;
  logic                  lat_en, live_en, cur_en;
  logic [NUM_DIGITS-1:0] an_on;
  logic [6:0]            seg_on;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  always_comb begin
    live_nib = '0;
    live_dp  = 1'b0;
    live_en  = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IW'(k)) begin
        live_nib = digits[4*k +: 4];
        live_dp  = dp_in[k];
        live_en  = digit_en[k];
      end
    end
  end

  // At cnt==0 the snapshot is being taken this cycle, so use the live value directly.
  assign cur_nib = (cnt == '0) ? live_nib : lat_nib;
  assign cur_dp  = (cnt == '0) ? live_dp  : lat_dp;
  assign cur_en  = (cnt == '0) ? live_en  : lat_en;
  assign seg_on  = hex7(cur_nib);

  always_comb begin
    an_on = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      an_on[k] = enable && cur_en && (cnt >= CNT_BLANK) && (idx == IW'(k));
    end
  end

  assign scan_tick = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      idx     <= '0;
      lat_nib <= '0;
      lat_dp  <= 1'b0;
      lat_en  <= 1'b0;
    end else begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end else begin
        cnt <= cnt + CW'(1);
      end
      if (cnt == '0) begin
        lat_nib <= live_nib;
        lat_dp  <= live_dp;
        lat_en  <= live_en;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an        <= {NUM_DIGITS{ACTIVE_LOW}};
      seg       <= {7{ACTIVE_LOW}};
      dp        <= ACTIVE_LOW;
      digit_idx <= '0;
    end else begin
      an        <= {NUM_DIGITS{ACTIVE_LOW}} ^ an_on;
      seg       <= {7{ACTIVE_LOW}} ^ seg_on;
      dp        <= ACTIVE_LOW ^ cur_dp;
      digit_idx <= idx;
    end
  end

endmodule

// File: tb/tb_an_scan_controller.sv
// tb/tb_an_scan_controller.sv - directed bench for the seven-segment scanner
module tb_an_scan_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        enable;
  logic [15:0] digits;
  logic [3:0]  dp_in, digit_en;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [1:0]  digit_idx;
  logic        scan_tick;

  logic        enable8;
  logic [31:0] digits8;
  logic [7:0]  dp_in8, digit_en8;
  logic [7:0]  an8;
  logic [6:0]  seg8;
  logic        dp8;
  logic [2:0]  digit_idx8;
  logic        scan_tick8;

  an_scan_controller #(.NUM_DIGITS(4), .CLK_DIV(8), .BLANK_CYCLES(2), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .digits(digits), .dp_in(dp_in),
    .digit_en(digit_en), .an(an), .seg(seg), .dp(dp), .digit_idx(digit_idx),
    .scan_tick(scan_tick)
  );

  an_scan_controller #(.NUM_DIGITS(8), .CLK_DIV(8), .BLANK_CYCLES(2), .ACTIVE_LOW(1'b0)) dut8 (
    .clk(clk), .reset_n(reset_n), .enable(enable8), .digits(digits8), .dp_in(dp_in8),
    .digit_en(digit_en8), .an(an8), .seg(seg8), .dp(dp8), .digit_idx(digit_idx8),
    .scan_tick(scan_tick8)
  );

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] idx;
    logic       tick;
  } vec_t;

  vec_t       tbl[13];
  logic [6:0] exp8[8];
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(5);
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int on_cnt[4];
    int multi;
    int low_cnt;

    // {cycle after release, an, seg, dp, digit_idx, scan_tick}
    tbl[0]  = '{0,  4'hF, 7'h7F, 1'b1, 2'd0, 1'b0};
    tbl[1]  = '{1,  4'hF, 7'h40, 1'b1, 2'd0, 1'b0};
    tbl[2]  = '{2,  4'hF, 7'h40, 1'b1, 2'd0, 1'b0};
    tbl[3]  = '{3,  4'hE, 7'h40, 1'b1, 2'd0, 1'b0};
    tbl[4]  = '{7,  4'hE, 7'h40, 1'b1, 2'd0, 1'b1};
    tbl[5]  = '{8,  4'hE, 7'h40, 1'b1, 2'd0, 1'b0};
    tbl[6]  = '{9,  4'hF, 7'h79, 1'b1, 2'd1, 1'b0};
    tbl[7]  = '{11, 4'hD, 7'h79, 1'b1, 2'd1, 1'b0};
    tbl[8]  = '{19, 4'hB, 7'h24, 1'b0, 2'd2, 1'b0};
    tbl[9]  = '{27, 4'h7, 7'h30, 1'b1, 2'd3, 1'b0};
    tbl[10] = '{31, 4'h7, 7'h30, 1'b1, 2'd3, 1'b1};
    tbl[11] = '{33, 4'hF, 7'h40, 1'b1, 2'd0, 1'b0};
    tbl[12] = '{35, 4'hE, 7'h40, 1'b1, 2'd0, 1'b0};
    exp8 = '{7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F};

    enable = 1'b1;  digits = 16'h3210;  dp_in = 4'b0100;  digit_en = 4'hF;
    enable8 = 1'b1; digits8 = 32'h89ABCDEF; dp_in8 = 8'h00; digit_en8 = 8'hFF;

    reset_n = 1'b0;
    step(5);
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp, 1'b1);
    chk("rst_idx", digit_idx, 2'd0);
    chk("rst_tick", scan_tick, 1'b0);
    chk("rst_an8", an8, 8'h00);
    chk("rst_seg8", seg8, 7'h00);
    reset_n = 1'b1;

    for (int k = 0; k < 4; k++) on_cnt[k] = 0;
    multi = 0;
    for (int c = 0; c <= 60; c++) begin
      if (c > 0) step(1);
      for (int v = 0; v < 13; v++) begin
        if (tbl[v].cyc == c) begin
          chk($sformatf("an@%0d", c), an, tbl[v].an);
          chk($sformatf("seg@%0d", c), seg, tbl[v].seg);
          chk($sformatf("dp@%0d", c), dp, tbl[v].dp);
          chk($sformatf("idx@%0d", c), digit_idx, tbl[v].idx);
          chk($sformatf("tick@%0d", c), scan_tick, tbl[v].tick);
        end
      end
      if (c >= 1 && c <= 32) begin
        for (int k = 0; k < 4; k++) if (!an[k]) on_cnt[k]++;
        if ($countones(~an) > 1) multi++;
      end
      if (c % 8 == 3) begin
        chk($sformatf("an8@%0d", c), an8, 8'h01 << (c / 8));
        chk($sformatf("seg8@%0d", c), seg8, exp8[c / 8]);
        chk($sformatf("idx8@%0d", c), digit_idx8, c / 8);
      end
      if (c % 8 == 1) chk($sformatf("an8_blank@%0d", c), an8, 8'h00);
    end
    for (int k = 0; k < 4; k++) chk($sformatf("on_cycles_an%0d", k), on_cnt[k], 6);
    chk("one_hot", multi, 0);

    // digit 2 disabled: its slot stays dark, neighbours untouched
    digit_en = 4'b1011;
    do_reset();
    step(11); chk("den_an@11", an, 4'hD);
    low_cnt = 0;
    for (int c = 12; c <= 24; c++) begin
      step(1);
      if (c >= 17 && an != 4'hF) low_cnt++;
    end
    chk("den_slot2_dark", low_cnt, 0);
    step(3);  chk("den_an@27", an, 4'h7);
    step(8);  chk("den_an@35", an, 4'hE);
    digit_en = 4'hF;

    // mid-slot digit change is held until the digit's next slot
    do_reset();
    step(4);  digits = 16'h321F;
    step(4);  chk("tear_seg@8", seg, 7'h40);
    step(1);  chk("tear_seg@9", seg, 7'h79);
    step(24); chk("tear_seg@33", seg, 7'h0E);
    step(2);  chk("tear_an@35", an, 4'hE);
    digits = 16'h3210;

    // enable drop mid-slot; counters keep running
    do_reset();
    step(12); chk("en_an@12", an, 4'hD);
    enable = 1'b0;
    low_cnt = 0;
    for (int c = 13; c <= 22; c++) begin
      step(1);
      if (an != 4'hF) low_cnt++;
    end
    chk("en_off_dark", low_cnt, 0);
    enable = 1'b1;
    step(1);
    chk("en_resume_an", an, 4'hB);
    chk("en_resume_idx", digit_idx, 2'd2);
    chk("en_resume_tick", scan_tick, 1'b1);

    // asynchronous reset in the middle of slot 2
    do_reset();
    step(20); chk("ar_an@20", an, 4'hB);
    chk("ar_dp@20", dp, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_an_async", an, 4'hF);
    chk("ar_seg_async", seg, 7'h7F);
    chk("ar_dp_async", dp, 1'b1);
    chk("ar_idx_async", digit_idx, 2'd0);
    chk("ar_an8_async", an8, 8'h00);
    step(4);
    reset_n = 1'b1;
    step(1);
    chk("ar_seg@1", seg, 7'h40);
    chk("ar_idx@1", digit_idx, 2'd0);
    step(2);  chk("ar_an@3", an, 4'hE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
